// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for the 8-bit four-register multi-cycle CPU. It steps each
//   instruction through fetch, decode, execute, memory and writeback, and
//   drives the datapath strobes for each step.
//   Instruction word: [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm2.
//   The jmp target is [5:0].
//
// Ports
//   clk, rst_n   clock (rising edge); asynchronous active-low reset
//   run          start/continue; only sampled in IDLE and when an instruction retires
//   instr        instruction word, taken into IR when mem_ack=1 in FETCH
//   mem_ack      memory handshake for the current mem_req
//   mem_req/we   memory request; we=1 marks a store
//   ir_we        IR load strobe
//   pc_we        PC update strobe
//   pc_src       PC source: 0 = PC+1, 1 = jump target
//   alu_src_imm  ALU operand B source: 1 = sign-extended imm2, 0 = register rt
//   reg_we       register file write strobe
//   reg_dst      write-back register: 1 = rd (add), 0 = rt (lw)
//   mem_to_reg   write-back data source: 1 = memory, 0 = ALU
//   state        current FSM state (debug)
//   fault        sticky memory-timeout flag
//   retired      number of completed instructions, wraps at 8 bits
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       alu_src_imm,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  // A timeout fires on the MEM_WAIT_MAX-th consecutive cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] op_q;
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       retire;
  logic       wait_expired;

  assign state        = state_q;
  assign fault        = fault_q;
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      wait_cnt <= 8'd0;
      fault_q  <= 1'b0;
      retired  <= 8'd0;
    end else begin
      state_q <= state_d;
      if (ir_we) op_q <= instr[7:6];
      // mem_req is only high in FETCH/MEM. This clears the counter on entry
      // to those states, on every ack, and everywhere else.
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                     wait_cnt <= 8'd0;
      if (state_d == S_FAULT) fault_q <= 1'b1;
      if (retire)             retired <= retired + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (op_q)
          OP_ADD: state_d = S_WB;
          OP_LW, OP_SW: begin
            alu_src_imm = 1'b1;
            state_d     = S_MEM;
          end
          default: begin // OP_JMP
            pc_we  = 1'b1;
            pc_src = 1'b1;
            retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req     = 1'b1;
        alu_src_imm = 1'b1;
        mem_we      = (op_q == OP_SW);
        if (mem_ack) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               retire  = 1'b1;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (op_q == OP_ADD);
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    // run is only looked at on instruction boundaries.
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic       clk, rst_n, run, mem_ack;
  logic [7:0] instr;
  logic       mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_imm;
  logic       reg_we, reg_dst, mem_to_reg, fault;
  logic [2:0] state;
  logic [7:0] retired;

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_imm(alu_src_imm), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .fault(fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_imm, reg_we, reg_dst, mem_to_reg}
  function automatic logic [8:0] ctrl_now();
    return {mem_req, mem_we, ir_we, pc_we, pc_src, alu_src_imm, reg_we, reg_dst, mem_to_reg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Drive the inputs mid-cycle, then let the combinational outputs settle.
  task automatic tick(input logic r, input logic [7:0] i, input logic a);
    @(negedge clk);
    run = r; instr = i; mem_ack = a;
    #1;
  endtask

  typedef struct {
    logic       run;
    logic [7:0] instr;
    logic       ack;
    logic [2:0] st;
    logic [8:0] ctrl;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // add, with run dropped mid-instruction (ignored there)
    tbl.push_back('{1'b1, 8'h1B, 1'b1, 3'd0, 9'h000, 8'd0});
    tbl.push_back('{1'b1, 8'h1B, 1'b1, 3'd1, 9'h160, 8'd0});
    tbl.push_back('{1'b0, 8'h1B, 1'b1, 3'd2, 9'h000, 8'd0});
    tbl.push_back('{1'b0, 8'h1B, 1'b1, 3'd3, 9'h000, 8'd0});
    tbl.push_back('{1'b1, 8'h1B, 1'b1, 3'd5, 9'h006, 8'd0});
    // lw, with the ack delayed 3 cycles in MEM
    tbl.push_back('{1'b1, 8'h46, 1'b1, 3'd1, 9'h160, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b1, 3'd2, 9'h000, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b1, 3'd3, 9'h008, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b0, 3'd4, 9'h108, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b0, 3'd4, 9'h108, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b0, 3'd4, 9'h108, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b1, 3'd4, 9'h108, 8'd1});
    tbl.push_back('{1'b1, 8'h46, 1'b1, 3'd5, 9'h005, 8'd1});
    // jmp
    tbl.push_back('{1'b1, 8'hC5, 1'b1, 3'd1, 9'h160, 8'd2});
    tbl.push_back('{1'b1, 8'hC5, 1'b1, 3'd2, 9'h000, 8'd2});
    tbl.push_back('{1'b1, 8'hC5, 1'b1, 3'd3, 9'h030, 8'd2});
    // sw, with run=0 at its retire, then IDLE ignoring the ack
    tbl.push_back('{1'b1, 8'h87, 1'b1, 3'd1, 9'h160, 8'd3});
    tbl.push_back('{1'b1, 8'h87, 1'b1, 3'd2, 9'h000, 8'd3});
    tbl.push_back('{1'b1, 8'h87, 1'b1, 3'd3, 9'h008, 8'd3});
    tbl.push_back('{1'b0, 8'h87, 1'b1, 3'd4, 9'h188, 8'd3});
    tbl.push_back('{1'b0, 8'h87, 1'b1, 3'd0, 9'h000, 8'd4});
    tbl.push_back('{1'b0, 8'h87, 1'b1, 3'd0, 9'h000, 8'd4});

    rst_n = 1'b0; run = 1'b0; instr = 8'h00; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(ctrl_now()), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].run, tbl[i].instr, tbl[i].ack);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ctrl));
      chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(tbl[i].ret));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'd0);
    end

    // Assert reset asynchronously while MEM of an lw is requesting memory.
    tick(1'b1, 8'h46, 1'b1);
    tick(1'b1, 8'h46, 1'b1);
    tick(1'b1, 8'h46, 1'b1);
    tick(1'b1, 8'h46, 1'b1);
    tick(1'b1, 8'h46, 1'b0);
    chk("arst_pre_state", 32'(state), 32'd4);
    chk("arst_pre_ctrl", 32'(ctrl_now()), 32'h108);
    chk("arst_pre_retired", 32'(retired), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ctrl", 32'(ctrl_now()), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    @(posedge clk);
    tick(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;

    // Run 256 adds so retired wraps to 0. run drops in the last DECODE,
    // so that add still completes and the FSM then goes idle.
    tick(1'b1, 8'h1B, 1'b1);
    chk("wrap_idle", 32'(state), 32'd0);
    for (int k = 0; k < 256; k++) begin
      logic r;
      r = (k != 255);
      tick(1'b1, 8'h1B, 1'b1);
      if (k == 0) chk("wrap_fetch0", 32'(state), 32'd1);
      tick(r, 8'h1B, 1'b1);
      if (k == 255) chk("wrap_last_decode", 32'(state), 32'd2);
      tick(r, 8'h1B, 1'b1);
      tick(r, 8'h1B, 1'b1);
      if (k == 128) chk("wrap_mid_retired", 32'(retired), 32'd128);
      if (k == 255) begin
        chk("wrap_last_wb", 32'(state), 32'd5);
        chk("wrap_pre_retired", 32'(retired), 32'd255);
      end
    end
    tick(1'b0, 8'h1B, 1'b1);
    chk("wrap_end_state", 32'(state), 32'd0);
    chk("wrap_retired", 32'(retired), 32'd0);
    chk("wrap_end_ctrl", 32'(ctrl_now()), 32'd0);

    // sw with mem_ack held low in MEM: FAULT after 15 waiting cycles.
    tick(1'b1, 8'h87, 1'b1);
    tick(1'b1, 8'h87, 1'b1);
    chk("flt_fetch", 32'(state), 32'd1);
    tick(1'b1, 8'h87, 1'b1);
    tick(1'b1, 8'h87, 1'b1);
    chk("flt_exec", 32'(state), 32'd3);
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, 8'h87, 1'b0);
      chk($sformatf("flt_wait%0d_state", i), 32'(state), 32'd4);
      if (i == 0 || i == 14) chk($sformatf("flt_wait%0d_ctrl", i), 32'(ctrl_now()), 32'h188);
    end
    tick(1'b1, 8'h87, 1'b0);
    chk("flt_state", 32'(state), 32'd6);
    chk("flt_fault", 32'(fault), 32'd1);
    chk("flt_ctrl", 32'(ctrl_now()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h87, 1'b1);
      chk($sformatf("flt_hold%0d_state", i), 32'(state), 32'd6);
      chk($sformatf("flt_hold%0d_fault", i), 32'(fault), 32'd1);
      chk($sformatf("flt_hold%0d_ctrl", i), 32'(ctrl_now()), 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("flt_rst_fault", 32'(fault), 32'd0);
    chk("flt_rst_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
